// File: rtl/pulse_interval_meter.sv
// Measures the tick count between a start pulse and a stop pulse,
// and classifies it as short, long or overflowed against a window.
module pulse_interval_meter #(
    parameter int WIDTH     = 16,
    parameter int MIN_TICKS = 10,
    parameter int MAX_TICKS = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             short,
    output logic             long,
    output logic             ovf
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Window limits may exceed the counter range (e.g. a narrow
    // counter with the default window), so compare at >= 32 bits.
    localparam int CW = (WIDTH > 32) ? WIDTH : 32;
    localparam logic [CW-1:0] MIN_C = CW'(MIN_TICKS);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_TICKS);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [CW-1:0]    cnt_ext;
    logic             at_limit;
    logic             is_short;
    logic             is_long;

    // Window classification of the count about to be latched.
    always_comb begin
        cnt_ext  = CW'(cnt);
        at_limit = (cnt == CNT_MAX);
        is_short = (cnt_ext < MIN_C);
        is_long  = (cnt_ext > MAX_C);
    end

    assign busy = (state == RUN);

    // Measurement FSM: counts ticks in RUN, latches result on stop
    // or on reaching the counter limit; start always (re)arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            short  <= 1'b0;
            long   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= CNT_ONE;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        result <= cnt;
                        done   <= 1'b1;
                        short  <= is_short;
                        long   <= is_long;
                        ovf    <= 1'b0;
                        if (start) begin
                            cnt <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (at_limit) begin
                        // Counter saturated without a stop: report
                        // overflow rather than wrapping.
                        result <= CNT_MAX;
                        done   <= 1'b1;
                        short  <= 1'b0;
                        long   <= 1'b1;
                        ovf    <= 1'b1;
                        if (start) begin
                            cnt <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start) begin
                        // Retrigger: drop the running measurement.
                        cnt <= CNT_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Randomized self-checking bench for pulse_interval_meter, using a
// 16-bit instance and a 4-bit instance for overflow scenarios.
module tb_pulse_interval_meter;

    localparam int MINT = 10;
    localparam int MAXT = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done, short, long, ovf;
    logic [15:0] result;

    logic        start4 = 1'b0;
    logic        stop4 = 1'b0;
    logic        busy4, done4, short4, long4, ovf4;
    logic [3:0]  result4;

    int checks = 0;
    int failures = 0;
    int n_done = 0;

    pulse_interval_meter #(.WIDTH(16), .MIN_TICKS(MINT), .MAX_TICKS(MAXT)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .busy(busy), .done(done), .result(result),
        .short(short), .long(long), .ovf(ovf)
    );

    pulse_interval_meter #(.WIDTH(4), .MIN_TICKS(MINT), .MAX_TICKS(MAXT)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .stop(stop4),
        .busy(busy4), .done(done4), .result(result4),
        .short(short4), .long(long4), .ovf(ovf4)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: stop k edges after start gives k ticks, flags by window.
    task automatic measure(input int k, input string name);
        logic [4:0] exp_fl;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i < k; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy at tick %0d: got %b want 1", name, i, busy);
            end
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        exp_fl = {1'b1, 1'b0, k < MINT, k > MAXT, 1'b0};
        checks++;
        if (result !== 16'(k)) begin
            failures++;
            $display("FAIL %s result: got %0d want %0d", name, result, k);
        end
        checks++;
        if ({done, busy, short, long, ovf} !== exp_fl) begin
            failures++;
            $display("FAIL %s flags{done,busy,short,long,ovf}: got %b want %b",
                     name, {done, busy, short, long, ovf}, exp_fl);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done width: got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, short, long, ovf, result} !== 21'd0) begin
            failures++;
            $display("FAIL reset16 outputs: got %b want 0",
                     {busy, done, short, long, ovf, result});
        end
        checks++;
        if ({busy4, done4, short4, long4, ovf4, result4} !== 9'd0) begin
            failures++;
            $display("FAIL reset4 outputs: got %b want 0",
                     {busy4, done4, short4, long4, ovf4, result4});
        end
        reset = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_basic();
        measure(25, "basic25");
    endtask

    task automatic test_window();
        int k;
        measure(5, "short5");
        measure(60, "long60");
        measure(9, "edge9");
        measure(10, "edge10");
        measure(50, "edge50");
        measure(51, "edge51");
        measure(1, "min1");
        for (int n = 0; n < 20; n++) begin
            k = $urandom_range(1, 80);
            measure(k, "rand");
        end
    endtask

    task automatic test_retrigger();
        int k, r, d0;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin
                k = 19; r = 7;
            end else begin
                k = $urandom_range(20, 70);
                r = $urandom_range(1, k - 1);
            end
            d0 = n_done;
            start = 1'b1; tick(); start = 1'b0;
            repeat (r - 1) tick();
            start = 1'b1; tick(); start = 1'b0;
            repeat (k - r - 1) tick();
            stop = 1'b1; tick(); stop = 1'b0;
            checks++;
            if (result !== 16'(k - r) || done !== 1'b1) begin
                failures++;
                $display("FAIL retrigger result/done: got %0d/%b want %0d/1",
                         result, done, k - r);
            end
            tick();
            checks++;
            if (n_done !== d0 + 1) begin
                failures++;
                $display("FAIL retrigger done count: got %0d want %0d",
                         n_done - d0, 1);
            end
        end
    endtask

    task automatic test_idle_stop();
        logic [15:0] r0;
        logic [2:0]  f0;
        int d0;
        r0 = result;
        f0 = {short, long, ovf};
        d0 = n_done;
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        checks++;
        if (n_done !== d0 || result !== r0 || {short, long, ovf} !== f0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_stop: got done=%0d res=%0d fl=%b busy=%b want 0/%0d/%b/0",
                     n_done - d0, result, {short, long, ovf}, busy, r0, f0);
        end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_start_stop busy/done: got %b/%b want 1/0", busy, done);
        end
        repeat (9) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if (result !== 16'd10 || done !== 1'b1 || short !== 1'b0) begin
            failures++;
            $display("FAIL idle_start_stop result: got %0d done=%b short=%b want 10/1/0",
                     result, done, short);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start = 1'b1; tick(); start = 1'b0;
        repeat (19) tick();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        checks++;
        if (result !== 16'd20 || done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b first: got res=%0d done=%b busy=%b want 20/1/1",
                     result, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b gap: got done=%b busy=%b want 0/1", done, busy);
        end
        repeat (11) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if (result !== 16'd13 || done !== 1'b1 || busy !== 1'b0 || short !== 1'b0) begin
            failures++;
            $display("FAIL b2b second: got res=%0d done=%b busy=%b short=%b want 13/1/0/0",
                     result, done, busy, short);
        end
        tick();
    endtask

    task automatic test_overflow();
        int at;
        at = -1;
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done4 === 1'b1) begin
                at = i;
                break;
            end
        end
        checks++;
        if (at !== 15) begin
            failures++;
            $display("FAIL ovf timing: got done at tick %0d want 15", at);
        end
        checks++;
        if ({result4, ovf4, long4, short4, busy4} !== {4'd15, 4'b1100}) begin
            failures++;
            $display("FAIL ovf outputs{res,ovf,long,short,busy}: got %b want %b",
                     {result4, ovf4, long4, short4, busy4}, {4'd15, 4'b1100});
        end
        tick();
        start4 = 1'b1; tick(); start4 = 1'b0;
        repeat (14) tick();
        stop4 = 1'b1; tick(); stop4 = 1'b0;
        checks++;
        if ({result4, ovf4, long4, short4, done4} !== {4'd15, 4'b0001}) begin
            failures++;
            $display("FAIL stop_at_limit{res,ovf,long,short,done}: got %b want %b",
                     {result4, ovf4, long4, short4, done4}, {4'd15, 4'b0001});
        end
        tick();
        start4 = 1'b1; tick(); start4 = 1'b0;
        repeat (14) tick();
        start4 = 1'b1; tick(); start4 = 1'b0;
        checks++;
        if ({done4, ovf4, busy4} !== 3'b111) begin
            failures++;
            $display("FAIL ovf_restart{done,ovf,busy}: got %b want 111",
                     {done4, ovf4, busy4});
        end
        repeat (2) tick();
        stop4 = 1'b1; tick(); stop4 = 1'b0;
        checks++;
        if ({result4, ovf4, long4, short4} !== {4'd3, 3'b001}) begin
            failures++;
            $display("FAIL ovf_restart result: got %b want %b",
                     {result4, ovf4, long4, short4}, {4'd3, 3'b001});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        measure(60, "pre_reset");
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        d0 = n_done;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({busy, done, short, long, ovf, result} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid outputs: got %b want 0",
                     {busy, done, short, long, ovf, result});
        end
        tick();
        checks++;
        if (n_done !== d0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid done/busy: got %0d/%b want 0/0", n_done - d0, busy);
        end
        measure(17, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_retrigger();
        test_idle_stop();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
